// File: rtl/ro_puf_pkg.sv
// Shared types and timing constants for the ring-oscillator PUF engine.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    SETTLE,
    CMP,
    DONE
  } state_e;

  localparam int unsigned ARM_CYCLES    = 2;  // RO start-up and synchronizer fill
  localparam int unsigned SETTLE_CYCLES = 3;  // drain after counting stops
  localparam int unsigned SYNC_STAGES   = 2;  // metastability flops per RO path

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one asynchronous RO output, detects rising edges and counts
// them into a saturating counter.
// Ports: clk, rst_n (synchronous, active-high), ro_raw (async RO output),
//        clr (zero the count), cnt_en (counting window), cnt (edge count).
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_raw,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   en_q;
  logic                   rise_c;

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // The enable is delayed one cycle so the first counted comparison already
  // sees two samples taken from the newly selected oscillator; the window
  // length is unchanged, it just slides into the first settle cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      en_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
      en_q   <= cnt_en;
      if (clr) begin
        cnt <= '0;
      end else if (en_q && rise_c && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF measurement engine: compares windowed edge counts of two
// challenge-selected oscillators and shifts the result into a response word.
// Ports: clk; rst_n (synchronous, active-high); ro_in (async RO bank outputs);
//        ro_en (RO bank enable); start/chal_a/chal_b/win_len (request);
//        busy/done/err (status); resp_bit/tie/count_a/count_b (last result);
//        resp_shift/resp_valid (accumulated responses).
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter  int unsigned NUM_RO    = 16,
  parameter  int unsigned CNT_W     = 12,
  parameter  int unsigned WIN_W     = 16,
  parameter  int unsigned RESP_BITS = 8,
  localparam int unsigned SEL_W     = $clog2(NUM_RO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RO-1:0]    ro_in,
  output logic                 ro_en,
  input  logic                 start,
  input  logic [SEL_W-1:0]     chal_a,
  input  logic [SEL_W-1:0]     chal_b,
  input  logic [WIN_W-1:0]     win_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 resp_bit,
  output logic                 tie,
  output logic [CNT_W-1:0]     count_a,
  output logic [CNT_W-1:0]     count_b,
  output logic [RESP_BITS-1:0] resp_shift,
  output logic                 resp_valid
);

  localparam int unsigned BC_W = $clog2(RESP_BITS + 1);

  state_e            state;
  logic [SEL_W-1:0]  sel_a_q;
  logic [SEL_W-1:0]  sel_b_q;
  logic [WIN_W-1:0]  win_q;
  logic [WIN_W-1:0]  timer_q;
  logic [BC_W-1:0]   bits_q;
  logic [CNT_W-1:0]  cnt_a_c;
  logic [CNT_W-1:0]  cnt_b_c;
  logic              chal_ok_c;
  logic              accept_c;
  logic              cnt_en_c;
  logic              gt_c;

  assign chal_ok_c = (chal_a != chal_b) && (32'(chal_a) < NUM_RO) && (32'(chal_b) < NUM_RO);
  assign accept_c  = (state == IDLE) && start && chal_ok_c;
  assign cnt_en_c  = (state == COUNT);
  assign gt_c      = (cnt_a_c > cnt_b_c);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_raw (ro_in[sel_a_q]),
    .clr    (accept_c),
    .cnt_en (cnt_en_c),
    .cnt    (cnt_a_c)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_raw (ro_in[sel_b_q]),
    .clr    (accept_c),
    .cnt_en (cnt_en_c),
    .cnt    (cnt_b_c)
  );

  // Measurement sequencer; timer_q counts down the remaining cycles of the
  // current phase.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      win_q      <= '0;
      timer_q    <= '0;
      bits_q     <= '0;
      ro_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      resp_bit   <= 1'b0;
      tie        <= 1'b0;
      count_a    <= '0;
      count_b    <= '0;
      resp_shift <= '0;
      resp_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (chal_ok_c) begin
              sel_a_q    <= chal_a;
              sel_b_q    <= chal_b;
              win_q      <= (win_len == '0) ? WIN_W'(1) : win_len;
              timer_q    <= WIN_W'(ARM_CYCLES - 1);
              ro_en      <= 1'b1;
              busy       <= 1'b1;
              resp_valid <= 1'b0;
              state      <= ARM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ARM: begin
          if (timer_q == '0) begin
            timer_q <= win_q - WIN_W'(1);
            state   <= COUNT;
          end else begin
            timer_q <= timer_q - WIN_W'(1);
          end
        end
        COUNT: begin
          if (timer_q == '0) begin
            timer_q <= WIN_W'(SETTLE_CYCLES - 1);
            ro_en   <= 1'b0;
            state   <= SETTLE;
          end else begin
            timer_q <= timer_q - WIN_W'(1);
          end
        end
        SETTLE: begin
          if (timer_q == '0) begin
            state <= CMP;
          end else begin
            timer_q <= timer_q - WIN_W'(1);
          end
        end
        CMP: begin
          resp_bit   <= gt_c;
          tie        <= (cnt_a_c == cnt_b_c);
          count_a    <= cnt_a_c;
          count_b    <= cnt_b_c;
          resp_shift <= {resp_shift[RESP_BITS-2:0], gt_c};
          if (bits_q != BC_W'(RESP_BITS)) begin
            bits_q <= bits_q + BC_W'(1);
          end
          if ((32'(bits_q) + 32'd1) >= RESP_BITS) begin
            resp_valid <= 1'b1;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_engine.sv
// Self-checking bench for ro_puf_engine: synthetic oscillators derived from a
// global cycle count, expected counts from window/period arithmetic.
module tb_ro_puf_engine;

  localparam int unsigned NRO = 16;
  localparam int unsigned RB  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ro_in;
  logic        start, start2;
  logic [3:0]  chal_a, chal_b;
  logic [15:0] win_len;

  logic        ro_en, busy, done, err, resp_bit, tie, resp_valid;
  logic [11:0] count_a, count_b;
  logic [7:0]  resp_shift;

  logic        ro_en2, busy2, done2, err2, resp_bit2, tie2, resp_valid2;
  logic [3:0]  count_a2, count_b2;
  logic [7:0]  resp_shift2;

  int          half[NRO];
  int          gcyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_shift[2];
  int          nbits[2];

  always #5 clk = ~clk;

  ro_puf_engine dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en), .start(start),
    .chal_a(chal_a), .chal_b(chal_b), .win_len(win_len), .busy(busy),
    .done(done), .err(err), .resp_bit(resp_bit), .tie(tie),
    .count_a(count_a), .count_b(count_b), .resp_shift(resp_shift),
    .resp_valid(resp_valid)
  );

  ro_puf_engine #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en2), .start(start2),
    .chal_a(chal_a), .chal_b(chal_b), .win_len(win_len), .busy(busy2),
    .done(done2), .err(err2), .resp_bit(resp_bit2), .tie(tie2),
    .count_a(count_a2), .count_b(count_b2), .resp_shift(resp_shift2),
    .resp_valid(resp_valid2)
  );

  // Square wave per oscillator: level = (gcyc / half) mod 2, so oscillators
  // with the same half period are phase aligned.
  always @(negedge clk) begin
    gcyc++;
    for (int i = 0; i < NRO; i++)
      ro_in[i] = (half[i] == 0) ? 1'b0 : 1'(((gcyc / half[i]) % 2));
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint exp, input int tol);
    total++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic accept_start(input int inst, input int a, input int b, input int w);
    @(negedge clk);
    chal_a  = 4'(a);
    chal_b  = 4'(b);
    win_len = 16'(w);
    if (inst == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // One measurement. Negative expectations mean "not checked".
  task automatic do_run(input int inst, input int a, input int b, input int w,
                        input int eb, input int et, input int eca, input int ecb,
                        input int tol, input bit poke);
    int   cyc;
    int   weff;
    int   ca, cb;
    logic d;
    accept_start(inst, a, b, w);
    cyc  = 1;
    weff = (w == 0) ? 1 : w;
    chk("busy_after_accept", (inst != 0) ? busy2 : busy, 1);
    chk("ro_en_after_accept", (inst != 0) ? ro_en2 : ro_en, 1);
    d = (inst != 0) ? done2 : done;
    while (!d && cyc < weff + 40) begin
      if (poke && cyc == 10) begin
        @(negedge clk);
        chal_a = 4'(a);
        chal_b = 4'(a);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        chk("err_while_busy", err, 0);
        chk("busy_while_busy", busy, 1);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
      d = (inst != 0) ? done2 : done;
    end
    chk("done_latency", cyc, weff + 7);
    ca = (inst != 0) ? int'(count_a2) : int'(count_a);
    cb = (inst != 0) ? int'(count_b2) : int'(count_b);
    if (eca >= 0) chk_near("count_a", ca, eca, tol);
    if (ecb >= 0) chk_near("count_b", cb, ecb, tol);
    if (et >= 0) chk("tie", (inst != 0) ? tie2 : tie, et);
    if (et == 1) chk("tie_counts_equal", ca, cb);
    if (eb >= 0) begin
      chk("resp_bit", (inst != 0) ? resp_bit2 : resp_bit, eb);
      exp_shift[inst] = {exp_shift[inst][6:0], 1'(eb)};
      nbits[inst]++;
      chk("resp_shift", (inst != 0) ? resp_shift2 : resp_shift, exp_shift[inst]);
      chk("resp_valid", (inst != 0) ? resp_valid2 : resp_valid, (nbits[inst] >= RB) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", (inst != 0) ? done2 : done, 0);
    chk("busy_released", (inst != 0) ? busy2 : busy, 0);
  endtask

  initial begin
    int pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int seen;
    int a, b, ha, hb, w, ea, ebc, tmp;

    for (int i = 0; i < NRO; i++) half[i] = 0;
    exp_shift[0] = '0; exp_shift[1] = '0;
    nbits[0] = 0; nbits[1] = 0;
    rst_n = 1'b1; start = 1'b0; start2 = 1'b0;
    chal_a = '0; chal_b = '0; win_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_resp_shift", resp_shift, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_resp_valid", resp_valid, 0);
    @(negedge clk) rst_n = 1'b0;

    // Period 4 vs period 6, both orders.
    half[3] = 2; half[5] = 3;
    do_run(0, 3, 5, 120, 1, 0, 30, 20, 1, 1'b0);
    do_run(0, 5, 3, 120, 0, 0, 20, 30, 1, 1'b1);
    chk("shift_bit0", resp_shift[0], 0);
    chk("shift_bit1", resp_shift[1], 1);

    // Two phase-aligned period-8 oscillators tie.
    half[2] = 4; half[7] = 4;
    do_run(0, 2, 7, 64, 0, 1, 8, 8, 1, 1'b0);

    // 4-bit counters saturate without wrapping.
    do_run(1, 3, 2, 200, 0, 1, 15, 15, 0, 1'b0);
    accept_start(1, 4, 4, 50);
    chk("err_pulse", err2, 1);
    chk("err_busy", busy2, 0);
    @(posedge clk); #1;
    chk("err_one_cycle", err2, 0);
    chk("err_busy_after", busy2, 0);
    chk("err_count_a_kept", count_a2, 15);
    chk("err_tie_kept", tie2, 1);
    chk("err_shift_kept", resp_shift2, exp_shift[1]);
    // Zero window behaves as one cycle.
    do_run(1, 3, 5, 0, -1, -1, -1, -1, 1, 1'b0);

    // Reset in the middle of the counting window.
    accept_start(0, 3, 5, 120);
    repeat (41) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_done", done, 0);
    chk("abort_shift", resp_shift, 0);
    chk("abort_count_a", count_a, 0);
    chk("abort_count_b", count_b, 0);
    chk("abort_resp_bit", resp_bit, 0);
    chk("abort_tie", tie, 0);
    chk("abort_valid", resp_valid, 0);
    @(negedge clk) rst_n = 1'b0;
    exp_shift[0] = '0; exp_shift[1] = '0;
    nbits[0] = 0; nbits[1] = 0;
    seen = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    do_run(0, 3, 5, 120, 1, 0, 30, 20, 1, 1'b0);

    // Eight back-to-back responses with a known ordering.
    for (int i = 0; i < 8; i++) begin
      if (pat[i] == 1) do_run(0, 3, 5, 60, 1, 0, 15, 10, 1, i == 3);
      else             do_run(0, 5, 3, 60, 0, 0, 10, 15, 1, i == 3);
    end
    chk("pattern_shift", resp_shift, 8'b10110010);
    chk("pattern_valid", resp_valid, 1);

    // Randomized pairs: fast vs slow oscillator with a clear count margin.
    for (int k = 0; k < 5; k++) begin
      a  = int'($urandom_range(0, 15));
      b  = (a + int'($urandom_range(1, 15))) % 16;
      ha = int'($urandom_range(2, 3));
      hb = int'($urandom_range(6, 8));
      if ($urandom_range(0, 1) == 1) begin
        tmp = ha; ha = hb; hb = tmp;
      end
      half[a] = ha;
      half[b] = hb;
      w   = int'($urandom_range(40, 150));
      ea  = w / (2 * ha);
      ebc = w / (2 * hb);
      do_run(0, a, b, w, (ea > ebc) ? 1 : 0, 0, ea, ebc, 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_puf_engine.md
Name: ro_puf_engine

Overview:
- Parametrised ring-oscillator PUF measurement engine.
- A challenge selects two oscillators from a bank of NUM_RO free-running ROs. The engine counts rising edges of each over a programmable window of clk cycles, compares the two counts and emits one response bit.
- Response bits accumulate into a RESP_BITS-wide shift register.
- Sits between the RO bank (which it enables via ro_en) and the top-level I/O wrapper. It replaces the free-running counter/comparator pair with a clocked, windowed and repeatable measurement.

Parameters:
- NUM_RO, 16, number of oscillator inputs (2..64).
- CNT_W, 12, edge-counter width; counters saturate.
- WIN_W, 16, width of the window-length input.
- RESP_BITS, 8, response shift-register length.
- SEL_W, $clog2(NUM_RO), challenge index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1 despite the name).
- ro_in  in  NUM_RO  raw oscillator outputs, asynchronous to clk.
- ro_en  out  1  oscillator enable, high only in ARM/COUNT.
- start  in  1  single-cycle request, sampled only in IDLE.
- chal_a  in  SEL_W  first RO index, captured with start.
- chal_b  in  SEL_W  second RO index, captured with start.
- win_len  in  WIN_W  counting window in clk cycles, captured with start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when the result is valid.
- err  out  1  one-cycle pulse on a rejected start.
- resp_bit  out  1  last response (count_a > count_b).
- tie  out  1  last comparison had equal counts.
- count_a  out  CNT_W  last count of chal_a.
- count_b  out  CNT_W  last count of chal_b.
- resp_shift  out  RESP_BITS  accumulated responses; newest bit in bit 0.
- resp_valid  out  1  high once RESP_BITS results are accumulated since reset/clear; clears on next accept.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including resp_shift, count_a, count_b, resp_valid and ro_en.
  - Internal counters and the bit counter clear.
  - Reset mid-measurement aborts with no done pulse.
- States: IDLE -> ARM(2) -> COUNT(win_len) -> SETTLE(3) -> CMP(1) -> DONE(1) -> IDLE.
- IDLE, start=1:
  - Rejected if chal_a==chal_b or either index >= NUM_RO. err pulses the next cycle, state stays IDLE, and no captured value changes.
  - Otherwise chal_a, chal_b and win_len are captured (win_len=0 treated as 1), edge counters clear, ro_en rises and the state goes to ARM.
- ARM: 2 cycles for oscillator start-up and synchronizer fill; no counting.
- COUNT: each selected RO is passed through a 2-flop synchronizer plus a rising-edge detector; each detected edge increments its counter. Counters saturate at 2^CNT_W-1 and never wrap. Lasts exactly win_len cycles.
- SETTLE: ro_en drops, counting stops and edges are ignored; 3 cycles.
- CMP:
  - resp_bit = (cnt_a > cnt_b).
  - tie = (cnt_a == cnt_b); a tie gives resp_bit=0.
  - count_a and count_b register the counts.
  - resp_shift <= {resp_shift[RESP_BITS-2:0], resp_bit}; the bit counter increments and saturates at RESP_BITS.
  - resp_valid sets when the bit counter reaches RESP_BITS.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: done is high exactly win_len+7 cycles after the accepting edge.
- busy covers accept+1 through the DONE cycle inclusive.
- start while busy is ignored, with no err.
- Counting is correct only for RO frequency < clk/2. The bench must respect this; silicon users derate win_len accordingly.
- Unselected ro_in bits are don't-care.
- resp_shift is cleared only by reset.

Decomposition:
- Package ro_puf_pkg:
  - state enum (IDLE, ARM, COUNT, SETTLE, CMP, DONE)
  - ARM_CYCLES=2, SETTLE_CYCLES=3, SYNC_STAGES=2
- Sub-module ro_edge_counter, instantiated twice:
  - Parameter CNT_W.
  - Inputs: clk, rst_n, ro_raw, clr, cnt_en.
  - Output: cnt.
  - Contains the synchronizer, edge detect and saturating counter.
- Both instances are fed by NUM_RO:1 muxes driven by the captured indices.

Test Plan:
- ro_in[3] toggles every 2 clk (period 4) and ro_in[5] every 3 clk (period 6); start with chal_a=3, chal_b=5, win_len=120 -> count_a=30±1, count_b=20±1, resp_bit=1, tie=0, done exactly 127 cycles after accept.
- Same stimulus with chal_a=5, chal_b=3 -> resp_bit=0, counts swapped; resp_shift bit0=0, bit1=1.
- ro_in[2] and ro_in[7] both of period 8, win_len=64, chal 2/7 -> count_a==count_b==8±1 and equal, tie=1, resp_bit=0.
- CNT_W=4, period-4 RO vs period-8 RO, win_len=200 -> count_a=15 (saturated, no wrap), count_b=15, tie=1; then error case chal_a=chal_b=4 -> err pulses one cycle, busy stays 0, outputs unchanged.
- Assert rst_n at cycle 40 of COUNT -> next cycle busy=0, ro_en=0, all outputs 0, no done pulse; a fresh start then completes normally.
- Eight back-to-back valid challenges with known ordering (1,0,1,1,0,0,1,0) -> resp_shift=8'b10110010, resp_valid=1 after the 8th done; start during busy ignored.
